// File: rtl/vlsu_pkg.sv
// Shared types and constants for the sequential vector load/store unit.
package vlsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WB,
    FIN
  } state_e;

  localparam int VLSU_VECTOR_WIDTH = 8;
  localparam int VLSU_ADDRESSWIDTH = 4;
  localparam int LANE_W            = $clog2(VLSU_VECTOR_WIDTH);

  // Register 15 aliases the PC and can never be a vector load/store target.
  localparam logic [VLSU_ADDRESSWIDTH-1:0] PC_ALIAS = '1;

endpackage

// File: rtl/vlsu_addr_gen.sv
// Address accumulator: loads base on start, adds the latched stride per handshake (mod 2^WIDTH).
module vlsu_addr_gen #(
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] stride_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] addr_o
);

  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] stride_q, stride_d;

  always_comb begin
    addr_d   = addr_q;
    stride_d = stride_q;
    if (load_i) begin
      addr_d   = base_i;
      stride_d = stride_i;
    end else if (step_i) begin
      addr_d = addr_q + stride_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      stride_q <= '0;
    end else begin
      addr_q   <= addr_d;
      stride_q <= stride_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/vlsu_seq.sv
// Sequential vector load/store: one element per memory handshake, base + lane*stride addressing.
// Optional VLSU_ELEM_WB_EN: per-element register file writes replace the single full-vector WB write.
module vlsu_seq
  import vlsu_pkg::*;
#(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = VLSU_VECTOR_WIDTH,
  parameter int ADDRESSWIDTH = VLSU_ADDRESSWIDTH
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic                                 is_store_i,
  input  logic [WIDTH-1:0]                     base_addr_i,
  input  logic [WIDTH-1:0]                     stride_i,
  input  logic [ADDRESSWIDTH-1:0]              vreg_i,
  input  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   store_data_v_i,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [WIDTH-1:0]                     mem_addr_o,
  output logic [WIDTH-1:0]                     mem_wdata_o,
  input  logic [WIDTH-1:0]                     mem_rdata_i,
  input  logic                                 mem_ready_i,
  output logic                                 rf_we_o,
  output logic                                 rf_isvector_o,
  output logic                                 rf_vect_esc_o,
  output logic [ADDRESSWIDTH-1:0]              rf_wd3_o,
  output logic [2:0]                           rf_index_A_o,
  output logic [WIDTH-1:0]                     rf_data_o,
  output logic [VECTOR_WIDTH-1:0][WIDTH-1:0]   rf_data_v_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 err_o
);

  state_e                           state_q;
  logic                             is_store_q;
  logic [ADDRESSWIDTH-1:0]          vreg_q;
  logic                             err_q;
  logic [LANE_W-1:0]                lane_q;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0] buf_q;
  logic [WIDTH-1:0]                 addr;

  logic xfer, hs, last_lane, accept, reject;

  assign xfer      = (state_q == XFER);
  assign hs        = xfer && mem_ready_i;
  assign last_lane = (lane_q == LANE_W'(VECTOR_WIDTH - 1));
  assign accept    = (state_q == IDLE) && start_i;
  assign reject    = (vreg_i == PC_ALIAS[ADDRESSWIDTH-1:0]);

  vlsu_addr_gen #(.WIDTH(WIDTH)) u_addr_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (accept),
    .base_i   (base_addr_i),
    .stride_i (stride_i),
    .step_i   (hs),
    .addr_o   (addr)
  );

`ifdef VLSU_ELEM_WB_EN
  logic              elem_we_q;
  logic [LANE_W-1:0] elem_idx_q;
  logic [WIDTH-1:0]  elem_data_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      vreg_q     <= '0;
      err_q      <= 1'b0;
      lane_q     <= '0;
      buf_q      <= '0;
`ifdef VLSU_ELEM_WB_EN
      elem_we_q   <= 1'b0;
      elem_idx_q  <= '0;
      elem_data_q <= '0;
`endif
    end else begin
`ifdef VLSU_ELEM_WB_EN
      elem_we_q <= hs && !is_store_q;
      if (hs) begin
        elem_idx_q  <= lane_q;
        elem_data_q <= mem_rdata_i;
      end
`endif
      case (state_q)
        IDLE: begin
          if (start_i) begin
            is_store_q <= is_store_i;
            vreg_q     <= vreg_i;
            lane_q     <= '0;
            err_q      <= reject;
            state_q    <= reject ? FIN : XFER;
          end
        end
        XFER: begin
          if (mem_ready_i) begin
            if (!is_store_q) buf_q[lane_q] <= mem_rdata_i;
            lane_q <= lane_q + 1'b1;
            if (last_lane) begin
`ifdef VLSU_ELEM_WB_EN
              state_q <= FIN;
`else
              state_q <= is_store_q ? FIN : WB;
`endif
            end
          end
        end
        WB: state_q <= FIN;
        FIN: begin
`ifdef VLSU_ELEM_WB_EN
          // Hold FIN while the last element write drains so done trails it by a cycle.
          if (!elem_we_q) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
          end
`else
          state_q <= IDLE;
          err_q   <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = xfer;
  assign mem_we_o    = xfer && is_store_q;
  assign mem_addr_o  = xfer ? addr : '0;
  assign mem_wdata_o = (xfer && is_store_q)
                     ? store_data_v_i[LANE_W'(VECTOR_WIDTH - 1) - lane_q] : '0;
  assign busy_o      = (state_q != IDLE);
  assign rf_data_v_o = buf_q;

`ifdef VLSU_ELEM_WB_EN
  assign done_o        = (state_q == FIN) && !elem_we_q;
  assign rf_we_o       = elem_we_q;
  assign rf_isvector_o = elem_we_q;
  assign rf_vect_esc_o = elem_we_q;
  assign rf_wd3_o      = elem_we_q ? vreg_q : '0;
  assign rf_index_A_o  = elem_we_q ? 3'(elem_idx_q) : 3'd0;
  assign rf_data_o     = elem_we_q ? elem_data_q : '0;
`else
  assign done_o        = (state_q == FIN);
  assign rf_we_o       = (state_q == WB);
  assign rf_isvector_o = (state_q == WB);
  assign rf_vect_esc_o = 1'b0;
  assign rf_wd3_o      = (state_q == WB) ? vreg_q : '0;
  assign rf_index_A_o  = 3'd0;
  assign rf_data_o     = '0;
`endif
  assign err_o = done_o && err_q;

endmodule

// File: tb/tb_vlsu_seq.sv
// Directed, table-driven bench for vlsu_seq; memory returns address + 0x10 on loads.
module tb_vlsu_seq;
  localparam int W  = 24;
  localparam int VW = 8;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n, start, is_store, mem_ready;
  logic [W-1:0]          base_addr, stride;
  logic [AW-1:0]         vreg;
  logic [VW-1:0][W-1:0]  store_data_v;
  logic                  mem_req, mem_we;
  logic [W-1:0]          mem_addr, mem_wdata, mem_rdata;
  logic                  rf_we, rf_isvector, rf_vect_esc;
  logic [AW-1:0]         rf_wd3;
  logic [2:0]            rf_index_A;
  logic [W-1:0]          rf_data;
  logic [VW-1:0][W-1:0]  rf_data_v;
  logic                  busy, done, err;

  int checks = 0;
  int errors = 0;

  assign mem_rdata = mem_addr + 24'h10;

  vlsu_seq #(.WIDTH(W), .VECTOR_WIDTH(VW), .ADDRESSWIDTH(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .is_store_i(is_store),
    .base_addr_i(base_addr), .stride_i(stride), .vreg_i(vreg),
    .store_data_v_i(store_data_v),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready),
    .rf_we_o(rf_we), .rf_isvector_o(rf_isvector), .rf_vect_esc_o(rf_vect_esc),
    .rf_wd3_o(rf_wd3), .rf_index_A_o(rf_index_A), .rf_data_o(rf_data),
    .rf_data_v_o(rf_data_v), .busy_o(busy), .done_o(done), .err_o(err)
  );

  typedef struct {
    bit           is_store;
    logic [W-1:0] base;
    logic [W-1:0] stride;
    logic [AW-1:0] vreg;
    int           stall_lane;
    int           stall_n;
    bit           pulse;
    int           exp_done;
    bit           exp_err;
    logic [W-1:0] exp_addr7;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int hs_cnt = 0;
    int req_cnt = 0;
    int rf_cnt = 0;
    int stall_left = v.stall_n;
    int done_cyc = -1;
    int wb_cyc = -1;
    logic [W-1:0] exp_a;
    logic [W-1:0] last_addr = '0;
    logic [W-1:0] held_addr = '0;
    logic [W-1:0] held_wdata = '0;
    bit was_stall = 0;
    @(posedge clk); #1;
    start = 1'b1; is_store = v.is_store; base_addr = v.base;
    stride = v.stride; vreg = v.vreg; mem_ready = 1'b1;
    for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (v.pulse && cyc == 3) begin
        start = 1'b1; vreg = 4'hF; is_store = ~v.is_store; base_addr = 24'h0;
      end
      mem_ready = !(hs_cnt == v.stall_lane && stall_left > 0);
      if (!mem_ready) stall_left--;
      @(negedge clk);
      if (mem_req) begin
        req_cnt++;
        chk("req_in_range", W'(hs_cnt < VW), 24'h1);
        exp_a = v.base + W'(hs_cnt) * v.stride;
        if (was_stall) begin
          chk("held_addr", mem_addr, held_addr);
          chk("held_wdata", mem_wdata, held_wdata);
        end
        if (mem_ready) begin
          chk("addr", mem_addr, exp_a);
          chk("we", W'(mem_we), W'(v.is_store));
          if (v.is_store) chk("wdata", mem_wdata, 24'hA0000 + W'(hs_cnt));
          last_addr = mem_addr;
          hs_cnt++;
          was_stall = 0;
        end else begin
          if (!was_stall) begin
            held_addr = mem_addr;
            held_wdata = mem_wdata;
          end
          was_stall = 1;
        end
      end
      if (rf_we) begin
`ifdef VLSU_ELEM_WB_EN
        chk("el_esc", W'(rf_vect_esc), 24'h1);
        chk("el_isvec", W'(rf_isvector), 24'h1);
        chk("el_idx", W'(rf_index_A), W'(rf_cnt));
        chk("el_data", rf_data, v.base + W'(rf_cnt) * v.stride + 24'h10);
        chk("el_wd3", W'(rf_wd3), W'(v.vreg));
`else
        wb_cyc = cyc;
        chk("wb_wd3", W'(rf_wd3), W'(v.vreg));
        chk("wb_isvec", W'(rf_isvector), 24'h1);
        chk("wb_esc", W'(rf_vect_esc), 24'h0);
        for (int i = 0; i < VW; i++)
          chk("wb_data", rf_data_v[i], v.base + W'(i) * v.stride + 24'h10);
`endif
        rf_cnt++;
      end
      if (done) begin
        done_cyc = cyc;
        chk("err", W'(err), W'(v.exp_err));
      end else begin
        chk("busy", W'(busy), 24'h1);
      end
    end
    chk("done_cycle", W'(done_cyc), W'(v.exp_done));
    chk("handshakes", W'(hs_cnt), v.exp_err ? 24'h0 : 24'h8);
    chk("addr_lane7", last_addr, v.exp_addr7);
    if (v.exp_err) chk("no_req", W'(req_cnt), 24'h0);
    if (v.is_store || v.exp_err) begin
      chk("no_rf_we", W'(rf_cnt), 24'h0);
    end else begin
`ifdef VLSU_ELEM_WB_EN
      chk("el_count", W'(rf_cnt), 24'h8);
`else
      chk("wb_count", W'(rf_cnt), 24'h1);
      chk("wb_cycle", W'(wb_cyc), W'(v.exp_done - 1));
`endif
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_pulse", W'(done), 24'h0);
    chk("idle_busy", W'(busy), 24'h0);
  endtask

  initial begin
    int bad;
    //            st  base        stride  vreg   lane n  pls done err addr7
    tbl[0] = '{1'b0, 24'h000100, 24'h1, 4'd3, 99, 0, 1'b0, 10, 1'b0, 24'h000107};
    tbl[1] = '{1'b1, 24'h000100, 24'h2, 4'd5, 99, 0, 1'b0,  9, 1'b0, 24'h00010E};
    tbl[2] = '{1'b0, 24'h000200, 24'h1, 4'd3,  4, 3, 1'b0, 13, 1'b0, 24'h000207};
    tbl[3] = '{1'b1, 24'h000100, 24'h2, 4'd5,  4, 3, 1'b0, 12, 1'b0, 24'h00010E};
    tbl[4] = '{1'b0, 24'hFFFFFE, 24'h1, 4'd2, 99, 0, 1'b0, 10, 1'b0, 24'h000005};
    tbl[5] = '{1'b0, 24'h000300, 24'h1, 4'hF, 99, 0, 1'b0,  1, 1'b1, 24'h000000};
    tbl[6] = '{1'b0, 24'h000100, 24'h1, 4'd3, 99, 0, 1'b1, 10, 1'b0, 24'h000107};
    tbl[7] = '{1'b0, 24'h000040, 24'h0, 4'd1, 99, 0, 1'b0, 10, 1'b0, 24'h000040};
    tbl[8] = '{1'b1, 24'hFFFFFC, 24'h3, 4'd6, 99, 0, 1'b0,  9, 1'b0, 24'h000011};

    for (int i = 0; i < VW; i++) store_data_v[VW-1-i] = 24'hA0000 + W'(i);
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; mem_ready = 1'b1;
    base_addr = '0; stride = '0; vreg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", W'(mem_req), 24'h0);
    chk("rst_mem_addr", mem_addr, 24'h0);
    chk("rst_rf_we", W'(rf_we), 24'h0);
    chk("rst_busy", W'(busy), 24'h0);
    chk("rst_done", W'(done), 24'h0);
    chk("rst_err", W'(err), 24'h0);
    chk("rst_rf_data_v", rf_data_v[0], 24'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int t = 0; t < 9; t++) run_op(tbl[t]);

    // Reset in cycle 4 of a load abandons it; a later request completes.
    @(posedge clk); #1;
    start = 1'b1; is_store = 1'b0; base_addr = 24'h000500; stride = 24'h1; vreg = 4'd7;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == 4) rst_n = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_mem_req", W'(mem_req), 24'h0);
    chk("mid_rst_busy", W'(busy), 24'h0);
    chk("mid_rst_done", W'(done), 24'h0);
    chk("mid_rst_rf_we", W'(rf_we), 24'h0);
    chk("mid_rst_mem_addr", mem_addr, 24'h0);
    chk("mid_rst_buf", rf_data_v[0], 24'h0);
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (mem_req || rf_we || done) bad++;
    end
    chk("mid_rst_quiet", W'(bad), 24'h0);
    run_op(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vlsu_seq.md
# vlsu_seq

Sequential vector load/store unit for the vector datapath. Moves one vector register (VECTOR_WIDTH lanes of WIDTH bits) to or from memory over a single WIDTH-bit memory port, one element per handshake, with base + stride addressing. Store data comes from the vector register file read port. Load results feed the register file write port through the we / isvector / vect_esc / index_A controls.

## Interface
- WIDTH, 24, element and memory address/data width
- VECTOR_WIDTH, 8, lanes per vector register
- ADDRESSWIDTH, 4, register-number width
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- is_store  in  1  1 = store vector to memory, 0 = load vector from memory
- base_addr  in  WIDTH  address of lane 0
- stride  in  WIDTH  address increment per lane, in words
- vreg  in  ADDRESSWIDTH  vector register to load into or store from
- store_data_v  in  [VECTOR_WIDTH][WIDTH]  register file vector read data; lane i is at slot VECTOR_WIDTH-1-i (lane 0 packed highest)
- mem_req  out  1  memory request valid
- mem_we  out  1  memory write enable, qualified by mem_req
- mem_addr  out  WIDTH  memory address
- mem_wdata  out  WIDTH  memory store data
- mem_rdata  in  WIDTH  memory load data; valid in the cycle mem_ready=1
- mem_ready  in  1  handshake completes when mem_req && mem_ready
- rf_we, rf_isvector, rf_vect_esc  out  1 each  register file write controls
- rf_wd3  out  ADDRESSWIDTH  register file write register
- rf_index_A  out  3  lane index for element writes
- rf_data  out  WIDTH  scalar element write data
- rf_data_v  out  [VECTOR_WIDTH][WIDTH]  full-vector write data; lane i at index i
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle completion pulse
- err  out  1  single-cycle pulse, coincident with done, for a rejected request

## Operation
- States: IDLE, XFER, WB, FIN.
- IDLE + start: latch is_store, base_addr, stride, vreg. Clear lane counter to 0. Go to XFER.
  - Exception: if vreg is all-ones (register 15, the PC alias), go to FIN with err=1. No memory traffic and no register file write occur.
- XFER: mem_req=1, mem_addr = base + lane*stride, computed modulo 2^WIDTH (wraps silently). mem_we=is_store.
  - For a store, mem_wdata = store_data_v[VECTOR_WIDTH-1-lane]. store_data_v must stay stable for the whole operation.
  - On handshake: a load captures mem_rdata into buf[lane]; the lane counter increments.
  - After the handshake on lane VECTOR_WIDTH-1: a load goes to WB, a store goes to FIN.
  - While mem_ready=0, mem_addr, mem_we and mem_wdata hold stable.
- WB (loads only): for one cycle, rf_we=1, rf_isvector=1, rf_vect_esc=0, rf_wd3=vreg, rf_data_v=buf. Then go to FIN.
- FIN: done=1 (err as latched). Return to IDLE.
- start while not in IDLE is ignored; no queuing.
- stride=0: every lane uses base_addr.

## Timing
- Reset values: every output 0, buf cleared, state IDLE. A reset mid-operation abandons the transfer with no further mem_req, rf_we or done.
- With mem_ready tied high, start accepted at cycle 0:
  - mem_req is high in cycles 1..8.
  - Load: WB write in cycle 9, done in cycle 10.
  - Store: done in cycle 9.
- Each mem_ready=0 cycle adds one cycle of latency.
- Rejected request: done and err both high in cycle 1.
- All outputs are registered or decoded from state and registers. There is no combinational path from mem_ready to mem_req.

## Configuration
- VLSU_ELEM_WB_EN defined: each load handshake on lane i is followed next cycle by an element write. That write has rf_we=1, rf_isvector=1, rf_vect_esc=1, rf_index_A=i, rf_data=captured element, rf_wd3=vreg.
  - The WB state is removed.
  - done follows one cycle after the last element write. With mem_ready high this is cycle 10, the same as the default build.
- Not defined: single full-vector write in WB, as above. rf_vect_esc and rf_index_A stay 0.

## Structure
- vlsu_pkg holds:
  - the state enum (IDLE, XFER, WB, FIN);
  - LANE_W = $clog2(VECTOR_WIDTH);
  - the PC-alias register constant (all-ones).
- Sub-module vlsu_addr_gen: address accumulator. Loads base on start, adds stride on each handshake, wraps modulo 2^WIDTH.

## Test plan
- Load: base=0x000100, stride=1, vreg=3, ready high, memory word = address+0x10 → mem_addr 0x100..0x107; rf_we in cycle 9 with rf_data_v[i]=0x110+i; done in cycle 10.
- Store: vreg=5, stride=2, store_data_v lane i = 0xA0000+i → writes at 0x100, 0x102..0x10E with data 0xA0000..0xA0007 in lane order; done in cycle 9.
- Backpressure: ready low for 3 cycles on lane 4 → address and data held stable; done delayed by 3 cycles; no lane skipped or duplicated.
- Boundaries: base=0xFFFFFE, stride=1 → addresses wrap to 0x000000..0x000005. vreg=4'hF → done and err in cycle 1 with no mem_req. start pulsed during busy → ignored.
- Reset: rst_n low in cycle 4 of a load → outputs 0 next cycle; no rf_we or done. A new request afterwards completes normally.
- VLSU_ELEM_WB_EN build: load → eight element writes with rf_index_A 0..7, rf_vect_esc=1, no full-vector write; done in cycle 10.
